// File: rtl/weight_enum_if.sv
// weight_enum_if: request/stream bundle for the weight_enum enumerator.
//
// Signals:
//   start   - request a new enumeration (requester -> enumerator)
//   weight  - requested number of ones, 0..6, 7 is illegal (requester -> enumerator)
//   o       - current 6-bit word (enumerator -> consumer)
//   o_valid - o holds a valid word (enumerator -> consumer)
//   o_ready - consumer accepts o (consumer -> enumerator)
//   last    - o is the final word of the sequence (enumerator -> consumer)
//   busy    - enumeration in progress (enumerator -> requester)
//   done    - one-cycle pulse after the final transfer (enumerator -> requester)
//   err     - one-cycle pulse after a start with weight 7 (enumerator -> requester)
//   idx     - ordinal of the word on o, present only with WEIGHT_ENUM_IDX_EN
//
// Modports: master = requester/consumer side, slave = enumerator side.
// Optional feature macro: WEIGHT_ENUM_IDX_EN.
interface weight_enum_if;
  logic       start;
  logic [2:0] weight;
  logic [5:0] o;
  logic       o_valid;
  logic       o_ready;
  logic       last;
  logic       busy;
  logic       done;
  logic       err;
`ifdef WEIGHT_ENUM_IDX_EN
  logic [4:0] idx;

  modport master (
    output start, weight, o_ready,
    input  o, o_valid, last, busy, done, err, idx
  );

  modport slave (
    input  start, weight, o_ready,
    output o, o_valid, last, busy, done, err, idx
  );
`else
  modport master (
    output start, weight, o_ready,
    input  o, o_valid, last, busy, done, err
  );

  modport slave (
    input  start, weight, o_ready,
    output o, o_valid, last, busy, done, err
  );
`endif
endinterface

// File: rtl/weight_enum.sv
// weight_enum: enumerates, in ascending numeric order, every 6-bit word with a
// requested popcount, one word per accepted transfer on a valid/ready stream.
//
// Ports:
//   clk - clock, all state updates on the rising edge
//   rst - synchronous active-high reset
//   bus - weight_enum_if.slave: start/weight request, o/o_valid/o_ready/last
//         stream, busy/done/err status, optional idx ordinal
//
// Optional feature macro: WEIGHT_ENUM_IDX_EN adds the idx ordinal counter.
// All outputs are registered.
module weight_enum (
  input  logic           clk,
  input  logic           rst,
  weight_enum_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e     state_q;
  logic [2:0] weight_q;
  logic [5:0] o_q;
  logic       o_valid_q;
  logic       last_q;
  logic       busy_q;
  logic       done_q;
  logic       err_q;
`ifdef WEIGHT_ENUM_IDX_EN
  logic [4:0] idx_q;
`endif

  // Smallest word of weight w: w ones packed at the bottom.
  function automatic logic [5:0] first_word(input logic [2:0] w);
    return 6'h3f >> (3'd6 - w);
  endfunction

  // Largest word of weight w: w ones packed at the top.
  function automatic logic [5:0] final_word(input logic [2:0] w);
    logic [5:0] ones;
    ones = 6'h3f >> (3'd6 - w);
    return ones << (3'd6 - w);
  endfunction

  // Next ascending word of the same popcount. Find the lowest "01" pair
  // (bit i set, bit i+1 clear), move that one up to i+1 and repack the ones
  // that were below it at the bottom. Everything stays within 6 bits; when no
  // such pair exists the word is final and the result is never used.
  logic [5:0] next_word;
  logic       found;
  logic [2:0] ones_below;
  logic [5:0] clear_mask;
  logic [5:0] refill;

  always_comb begin
    next_word  = o_q;
    found      = 1'b0;
    ones_below = '0;
    clear_mask = '0;
    refill     = '0;
    for (int i = 0; i < 5; i++) begin
      if (!found) begin
        if (o_q[i] && !o_q[i+1]) begin
          found      = 1'b1;
          clear_mask = (6'b000010 << i) - 6'd1;
          refill     = (6'b000001 << ones_below) - 6'd1;
          next_word  = (o_q & ~clear_mask) | (6'b000010 << i) | refill;
        end else if (o_q[i]) begin
          ones_below = ones_below + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      weight_q  <= '0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef WEIGHT_ENUM_IDX_EN
      idx_q     <= '0;
`endif
    end else begin
      // Pulses default low; set only on the cycle they report.
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (bus.weight == 3'd7) begin
              err_q <= 1'b1;
            end else begin
              state_q   <= StRun;
              weight_q  <= bus.weight;
              o_q       <= first_word(bus.weight);
              o_valid_q <= 1'b1;
              // Weights 0 and 6 have a single word, which is also the last.
              last_q    <= (first_word(bus.weight) == final_word(bus.weight));
              busy_q    <= 1'b1;
`ifdef WEIGHT_ENUM_IDX_EN
              idx_q     <= '0;
`endif
            end
          end
        end
        StRun: begin
          // o_valid is always high here; without o_ready everything holds.
          if (bus.o_ready) begin
            if (last_q) begin
              state_q   <= StDone;
              o_valid_q <= 1'b0;
              last_q    <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              o_q    <= next_word;
              last_q <= (next_word == final_word(weight_q));
`ifdef WEIGHT_ENUM_IDX_EN
              idx_q  <= idx_q + 5'd1;
`endif
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.o       = o_q;
  assign bus.o_valid = o_valid_q;
  assign bus.last    = last_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
`ifdef WEIGHT_ENUM_IDX_EN
  assign bus.idx     = idx_q;
`endif

endmodule
